// File: rtl/f32m_mult_arbiter_pkg.sv
// rtl/f32m_mult_arbiter_pkg.sv - shared widths, states and GF(3^{2M}) arithmetic for the multiplier arbiter
package f32m_mult_arbiter_pkg;

    localparam int M  = 3;
    localparam int W2 = 4 * M - 1;

    typedef logic [W2:0]      f32m_t;
    typedef logic [2*M-1:0]   f3m_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LOAD = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    localparam f32m_t F32M_ZERO = '0;
    localparam f32m_t F32M_ONE  = f32m_t'(1);

    // GF(3^3) = GF(3)[a]/(a^3 - a - 1): a^3 = a + 1, a^4 = a^2 + a
    function automatic f3m_t f3m_mul(f3m_t x, f3m_t y);
        int   t [5];
        f3m_t r;
        for (int k = 0; k < 5; k++) t[k] = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                t[i+j] += int'(x[2*i +: 2]) * int'(y[2*j +: 2]);
        r[1:0] = 2'((t[0] + t[3]) % 3);
        r[3:2] = 2'((t[1] + t[3] + t[4]) % 3);
        r[5:4] = 2'((t[2] + t[4]) % 3);
        return r;
    endfunction

    function automatic f3m_t f3m_add(f3m_t x, f3m_t y, logic sub);
        f3m_t r;
        for (int k = 0; k < M; k++)
            r[2*k +: 2] = sub ? 2'((int'(x[2*k +: 2]) + 3 - int'(y[2*k +: 2])) % 3)
                              : 2'((int'(x[2*k +: 2]) + int'(y[2*k +: 2])) % 3);
        return r;
    endfunction

    // GF(3^6) = GF(3^3)[i]/(i^2 + 1); low half is the real part
    function automatic f32m_t f32m_mul(f32m_t a, f32m_t b);
        f3m_t a0, a1, b0, b1;
        a0 = a[2*M-1:0];
        a1 = a[W2:2*M];
        b0 = b[2*M-1:0];
        b1 = b[W2:2*M];
        return {f3m_add(f3m_mul(a0, b1), f3m_mul(a1, b0), 1'b0),
                f3m_add(f3m_mul(a0, b0), f3m_mul(a1, b1), 1'b1)};
    endfunction

endpackage

// File: rtl/f32m_mult_arbiter_if.sv
// rtl/f32m_mult_arbiter_if.sv - requester-side bus of the shared multiplier arbiter
interface f32m_mult_arbiter_if
    import f32m_mult_arbiter_pkg::*;
#(
    parameter int N = 4
) ();
    logic [N-1:0]          req;
    logic [N*(W2+1)-1:0]   a_bus;
    logic [N*(W2+1)-1:0]   b_bus;
    f32m_t                 c;
    logic [N-1:0]          ack;
    logic                  busy;
    logic [2:0]            grant_id;

    modport master (output req, a_bus, b_bus, input c, ack, busy, grant_id);
    modport slave  (input req, a_bus, b_bus, output c, ack, busy, grant_id);
endinterface

// File: rtl/f32m_mult.sv
// rtl/f32m_mult.sv - GF(3^{2M}) multiplier; computes while reset is low, done L cycles after release
module f32m_mult
    import f32m_mult_arbiter_pkg::*;
#(
    parameter int L = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  f32m_t a,
    input  f32m_t b,
    output f32m_t p,
    output logic  done
);
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
            p    <= '0;
        end else if (!done) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'(L - 1)) begin
                done <= 1'b1;
                p    <= f32m_mul(a, b);
            end
        end
    end
endmodule

// File: rtl/f32m_mult_arbiter_rr_pick.sv
// rtl/f32m_mult_arbiter_rr_pick.sv - first set request at or after ptr, wrapping modulo N
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [2:0]   idx,
    output logic         valid
);
    int d;
    int best_d;

    // smallest rotational distance from ptr wins
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        best_d = N;
        d      = 0;
        for (int j = 0; j < N; j++) begin
            d = j - int'(ptr);
            if (d < 0) d = d + N;
            if (req[j] && d < best_d) begin
                best_d = d;
                idx    = 3'(j);
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/f32m_mult_arbiter.sv
// rtl/f32m_mult_arbiter.sv - round-robin sharing of one f32m_mult among N req/ack requesters
module f32m_mult_arbiter
    import f32m_mult_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int L = 3
) (
    input  logic                clk,
    input  logic                reset,
    f32m_mult_arbiter_if.slave  bus
);
    arb_state_t   state, next_state;
    logic [2:0]   ptr, grant_q, pick_idx;
    logic         pick_valid, req_g, mult_rst, mult_done;
    logic [N-1:0] ack_q;
    f32m_t        a_q, b_q, c_q, pick_a, pick_b, mult_p;

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // parked in reset outside WAIT so every product starts from a clean slate
    assign mult_rst = reset | (state != ARB_WAIT);

    f32m_mult #(.L(L)) u_mult (
        .clk   (clk),
        .reset (mult_rst),
        .a     (a_q),
        .b     (b_q),
        .p     (mult_p),
        .done  (mult_done)
    );

    always_comb begin
        pick_a = '0;
        pick_b = '0;
        req_g  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (pick_idx == 3'(k)) begin
                pick_a = bus.a_bus[k*(W2+1) +: (W2+1)];
                pick_b = bus.b_bus[k*(W2+1) +: (W2+1)];
            end
            if (grant_q == 3'(k)) req_g = bus.req[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (pick_valid) next_state = ARB_LOAD;
            ARB_LOAD: next_state = ARB_WAIT;
            ARB_WAIT: if (mult_done) next_state = ARB_RESP;
            ARB_RESP: if (!req_g) next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (pick_valid) begin
                    a_q     <= pick_a;
                    b_q     <= pick_b;
                    grant_q <= pick_idx;
                    ptr     <= (pick_idx == 3'(N - 1)) ? 3'd0 : pick_idx + 3'd1;
                end
                ARB_WAIT: if (mult_done) begin
                    c_q   <= mult_p;
                    ack_q <= N'(1) << grant_q;
                end
                ARB_RESP: if (!req_g) ack_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.c        = c_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = (state != ARB_IDLE);
    assign bus.grant_id = grant_q;
endmodule

// File: doc/f32m_mult_arbiter.md
# f32m_mult_arbiter

Round-robin arbiter and sequencer that shares one `f32m_mult` instance among N requesters. Each requester posts an operand pair in GF(3^{2M}) under a 4-phase req/ack handshake. The block latches the granted operands, runs the multiplier's start/done protocol, and returns the product. It sits between tower-field users (GF(3^{6M}) multiply, pairing loop stages) and a single area-expensive GF(3^{2M}) multiplier.

## Interface
- `N`, default 4: number of requesters, range 2..8.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  N  request per requester; level; held until ack.
- `a_bus`  in  N*(`W2`+1)  operand a; slice i = bits [(i+1)*(`W2`+1)-1 : i*(`W2`+1)].
- `b_bus`  in  N*(`W2`+1)  operand b; same slicing.
- `c`  out  `W2`+1  product of the granted request; valid while its ack is high.
- `ack`  out  N  one-hot; high from result capture until the granted req drops.
- `busy`  out  1  high in LOAD, WAIT and RESP.
- `grant_id`  out  3  index of the current or most recent grant.

## Operation
- States: IDLE, LOAD, WAIT, RESP. Encoding is 2 bits; IDLE=0.
- IDLE: if any `req` bit is high, pick the first set bit at or after `ptr`, wrapping modulo N.
  - Latch the granted a/b slices into `a_q`/`b_q`.
  - Set `grant_id` and `ptr <= (g+1) mod N`.
  - Go to LOAD.
  - If no request is pending, stay in IDLE.
- LOAD: the multiplier reset is high for exactly one cycle with `a_q`/`b_q` stable on its inputs. Go to WAIT.
- WAIT: the multiplier reset is low.
  - When the multiplier done is high, register its output into `c`, set `ack[g]=1`, and go to RESP.
  - The wait has no timeout.
- RESP: hold `ack[g]` and `c`.
  - When `req[g]==0`: clear `ack` and go to IDLE.
  - Other requests are not sampled while in RESP.
- Multiplier reset is `reset | (state!=WAIT)`. The multiplier is parked in reset whenever it is not computing.
- Operand changes by any requester after its grant are ignored, because operands are latched.
- Requests that arrive during LOAD/WAIT/RESP wait their turn. The round-robin order guarantees each pending requester is served within N grants.
- Simultaneous requests: the lowest index at or after `ptr` wins.
- A requester that raises req again immediately after its ack drops is treated as a new request. It competes normally, with its priority now rotated to last.

## Timing
- Reset values:
  - state=IDLE, `ptr`=0
  - `ack`=0, `busy`=0, `grant_id`=0
  - `c`=0, `a_q`=`b_q`=0
- Reset mid-operation: the in-flight product is abandoned with no ack. The multiplier is held in reset, and the arbiter is in IDLE on the edge after reset deasserts.
- Latency, with L = cycles from multiplier-reset deassertion to done high:
  - `req` is sampled at edge E0.
  - LOAD occupies cycle E0..E1.
  - `ack` and `c` become visible after edge E1+L+1, i.e. L+2 cycles after E0.
- Release: `ack` falls on the first edge that sees `req[g]` low. The next grant can occur on the following edge, giving a minimum of 1 idle cycle between products.
- Throughput is one product per L+4 cycles under continuous load.

## Structure
- The shared include holds:
  - the existing `W2` width macro;
  - state encodings `ARB_IDLE`, `ARB_LOAD`, `ARB_WAIT`, `ARB_RESP`;
  - the GF(3^{2M}) constants `F32M_ZERO` and `F32M_ONE` (one = low digit 1, all other digits 0).
- Sub-modules:
  - one `f32m_mult` instance;
  - one small combinational `rr_pick` module (N-bit req plus ptr in, index and valid out).

## Test plan
- Single request: req[2]=1, a=`F32M_ONE`, b=X -> ack[2] is high L+2 cycles after the first sample, c==X; ack drops one edge after req[2] falls.
- Zero operand: a=`F32M_ZERO`, b=X -> c==`F32M_ZERO`. Also check a=X, b=`F32M_ONE` -> c==X, confirming operand slicing.
- Contention: all 4 requesters high from reset, each holding its req through its ack -> grants are 0,1,2,3,0,… and each c matches the reference model of its own operands.
- Fairness: requester 0 re-requests every time immediately and requester 3 holds req -> requester 3 is granted within 2 grants of its request.
- Operand change: the granted requester flips a_bus after grant -> c still equals the product of the latched operands.
- Reset mid-WAIT: reset for 1 cycle during WAIT -> no ack and busy=0. A fresh request afterwards completes correctly with a grant starting at index 0.
